// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit count, segment patterns and the frame payload.
// Segment bit order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 3;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // One displayed frame: all digits plus the per-frame display controls.
  typedef struct packed {
    bcd_t [NUM_DIGITS-1:0] digit;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic                  blank_en;
  } frame_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; values 10..15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes eight BCD digits onto a common-anode display, one digit per DIV cycles.
// Inputs are snapshotted once per frame so a changing value never tears mid-scan.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] one,
  input  logic [3:0] ten,
  input  logic [3:0] hundred,
  input  logic [3:0] thousand,
  input  logic [3:0] tenThousand,
  input  logic [3:0] hundredThousand,
  input  logic [3:0] mil,
  input  logic [3:0] tenMil,
  input  logic       blankEn,
  input  logic [7:0] dpMask,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]         presc;
  logic [IDX_W-1:0]      idx;
  logic                  tick;
  frame_t                live;
  frame_t                snap;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  blank;
  logic [SEG_W-1:0]      seg_dec;

  assign live.digit    = {tenMil, mil, hundredThousand, tenThousand,
                          thousand, hundred, ten, one};
  assign live.dp_mask  = dpMask;
  assign live.blank_en = blankEn;

  assign tick = (presc == PW'(DIV - 1));

  // Prescaler, scan index and frame snapshot taken on the 7->0 wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      snap  <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx + IDX_W'(1);
      if (idx == IDX_W'(NUM_DIGITS - 1)) begin
        snap <= live;
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // lead_zero[k]: snapshot digits k..7 are all zero.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (snap.digit[NUM_DIGITS-1] == '0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lead_zero[k] = lead_zero[k+1] & (snap.digit[k] == '0);
    end
    blank = snap.blank_en & lead_zero[idx] & (idx != '0);
  end

  bcd_to_seg7 u_dec (
    .digit (snap.digit[idx]),
    .seg   (seg_dec)
  );

  // Output registers; a blanked digit keeps every anode off.
  always_ff @(posedge clk) begin
    if (reset || blank) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= seg_dec;
      dp  <= ~snap.dp_mask[idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at DIV=4: directed and random input sequences against a
// frame/slot reference model derived from the cycle count since reset.
module tb_seg7_scan_driver;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = DIV * 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dig [8];
  logic       blankEn;
  logic [7:0] dpMask;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  logic [3:0] m_dig [8];
  logic       m_bl;
  logic [7:0] m_dp;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIV(DIV)) dut (
    .clk             (clk),
    .reset           (reset),
    .one             (dig[0]),
    .ten             (dig[1]),
    .hundred         (dig[2]),
    .thousand        (dig[3]),
    .tenThousand     (dig[4]),
    .hundredThousand (dig[5]),
    .mil             (dig[6]),
    .tenMil          (dig[7]),
    .blankEn         (blankEn),
    .dpMask          (dpMask),
    .an              (an),
    .seg             (seg),
    .dp              (dp)
  );

  function automatic logic [6:0] exp_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic set_num(input int n);
    int v;
    v = n;
    for (int k = 0; k < 8; k++) begin
      dig[k] = 4'(v % 10);
      v = v / 10;
    end
  endtask

  // Advance one clock and compare the registered outputs with the model.
  task automatic step();
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    int         k;
    bit         blank;
    @(posedge clk);
    #1;
    if (reset) begin
      ea = 8'hFF; es = 7'h7F; ed = 1'b1;
      e = 0;
      for (int j = 0; j < 8; j++) m_dig[j] = 4'd0;
      m_bl = 1'b0;
      m_dp = 8'h00;
    end else begin
      e++;
      k = ((e - 1) / DIV) % 8;
      blank = m_bl && (k > 0);
      for (int j = k; j < 8; j++) if (m_dig[j] != 4'd0) blank = 1'b0;
      if (blank) begin
        ea = 8'hFF; es = 7'h7F; ed = 1'b1;
      end else begin
        ea = ~(8'd1 << k);
        es = exp_seg(m_dig[k]);
        ed = ~m_dp[k];
      end
      if (e % FRAME == 0) begin
        m_dig = dig;
        m_bl  = blankEn;
        m_dp  = dpMask;
      end
    end
    total++;
    assert (an === ea) else begin
      bad++;
      $error("FAIL an observed=%h expected=%h cycle=%0d", an, ea, e);
    end
    total++;
    assert (seg === es) else begin
      bad++;
      $error("FAIL seg observed=%b expected=%b cycle=%0d", seg, es, e);
    end
    total++;
    assert (dp === ed) else begin
      bad++;
      $error("FAIL dp observed=%b expected=%b cycle=%0d", dp, ed, e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the DUT's scan index (slot after the last edge) equals target.
  task automatic run_to_idx(input int target);
    int guard;
    guard = 0;
    while ((((e / DIV) % 8) != target) && (guard < 2 * FRAME)) begin
      step();
      guard++;
    end
    total++;
    assert (guard < 2 * FRAME) else begin
      bad++;
      $error("FAIL idx_wait observed=%0d expected=%0d", guard, 2 * FRAME);
    end
  endtask

  initial begin
    set_num(12345678);
    blankEn = 1'b1;
    dpMask  = 8'hA5;

    // Reset from power-up, then again with the prescaler mid-count.
    run(10);
    reset = 1'b0;
    run(6);
    reset = 1'b1;
    set_num(87654321);
    run(10);

    set_num(1337);
    blankEn = 1'b0;
    dpMask  = 8'h00;
    reset = 1'b0;
    run(3 * FRAME);

    blankEn = 1'b1;
    run(2 * FRAME + 5);

    set_num(0);
    run(2 * FRAME);

    // Change mid-frame: the old value must stay until the next frame load.
    set_num(1337);
    blankEn = 1'b0;
    run_to_idx(0);
    run(FRAME);
    run_to_idx(3);
    set_num(4);
    run(FRAME + 2 * DIV);

    set_num(0);
    dig[7]  = 4'hA;
    dpMask  = 8'h04;
    blankEn = 1'b1;
    run(2 * FRAME);

    // One-cycle reset pulse mid-scan restarts with a full first period.
    run_to_idx(5);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(FRAME + 3);

    for (int it = 0; it < 40; it++) begin
      int nz;
      nz = $urandom_range(0, 8);
      for (int k = 0; k < 8; k++)
        dig[k] = (k >= 8 - nz) ? 4'd0 : 4'($urandom_range(0, 15));
      blankEn = 1'($urandom_range(0, 1));
      dpMask  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        run(1);
        reset = 1'b0;
      end
      run($urandom_range(1, 40));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
